// File: rtl/stream_mux_nx1_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stream_mux_nx1_if                                         |
// | Purpose  : Producer-side and consumer-side stream bundle for the N:1 |
// |            stream mux. The slave modport is the mux itself.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface stream_mux_nx1_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                      mode;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_ready;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_ready;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface
`default_nettype wire

// File: rtl/stream_mux_nx1.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stream_mux_nx1                                            |
// | Purpose  : Registered N:1 valid/ready stream mux with round-robin or |
// |            fixed-priority arbitration and source-index tagging.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module stream_mux_nx1 #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  stream_mux_nx1_if.slave   bus
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam logic [SEL_W-1:0] c_last_ch  = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]   c_channels = (SEL_W + 1)'(CHANNELS);

  logic [WIDTH-1:0]    w_ch_data [CHANNELS];
  logic                w_load;
  logic                w_any;
  logic [SEL_W-1:0]    w_start;
  logic [SEL_W-1:0]    w_grant;
  logic [SEL_W-1:0]    w_next_ptr;
  logic [WIDTH-1:0]    w_data;
  logic [CHANNELS-1:0] w_ready;

  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic [SEL_W-1:0]    r_out_sel;
  logic [SEL_W-1:0]    r_rr_ptr;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
    assign w_ch_data[i] = bus.in_data[i*WIDTH +: WIDTH];
  end

  assign w_load  = !r_out_valid || bus.out_ready;
  assign w_any   = |bus.in_valid;
  // Fixed priority is just a round-robin search that always starts at 0.
  assign w_start = bus.mode ? '0 : r_rr_ptr;

  always_comb begin : arb
    logic             found;
    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] idx;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    w_grant = '0;
    w_data  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sum = {1'b0, w_start} + (SEL_W + 1)'(k);
      if (sum >= c_channels) sum = sum - c_channels;
      idx = sum[SEL_W-1:0];
      if (!found && bus.in_valid[idx]) begin
        found   = 1'b1;
        w_grant = idx;
        w_data  = w_ch_data[idx];
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_load && w_any) w_ready[w_grant] = 1'b1;
  end

  assign w_next_ptr = (w_grant == c_last_ch) ? '0 : w_grant + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data;
        r_out_sel   <= w_grant;
        r_rr_ptr    <= w_next_ptr;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;
endmodule
`default_nettype wire
